// File: rtl/tx_serial_16b.sv
// Sends a 16-bit word as two UART frames (start, 8 data LSB first, parity, stop) with an idle gap between them.
// Start bit leaves one clock after partida is sampled; partida is ignored while ocupado, accepted again in the pronto cycle.
module tx_serial_16b #(
  parameter int CLK_FREQ       = 50_000_000,
  parameter int BAUD           = 9600,
  parameter int PARIDADE_IMPAR = 1,
  parameter int GAP_BITS       = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        partida,
  input  logic [15:0] dados,
  output logic        saida_serial,
  output logic        ocupado,
  output logic        pronto,
  output logic [3:0]  db_estado
);

  localparam int M        = CLK_FREQ / BAUD;
  localparam int BW       = (M > 2) ? $clog2(M) : 1;
  localparam int GAP_CLKS = GAP_BITS * M;
  localparam int GW       = (GAP_CLKS > 2) ? $clog2(GAP_CLKS) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(M - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    PREPARA   = 4'd1,
    TRANSMITE = 4'd2,
    INTERVALO = 4'd3,
    FINAL     = 4'd4
  } estado_t;

  estado_t       estado, estado_n;
  logic [15:0]   dado_q, dado_n;
  logic [BW-1:0] baud_cnt, baud_cnt_n;
  logic [3:0]    bit_cnt, bit_cnt_n;
  logic [GW-1:0] gap_cnt, gap_cnt_n;
  logic          byte_sel, byte_sel_n;
  logic          linha_q, linha_n;
  logic [7:0]    byte_atual;
  logic          paridade;
  logic [10:0]   quadro;

  assign byte_atual = byte_sel ? dado_q[15:8] : dado_q[7:0];
  assign paridade   = (PARIDADE_IMPAR != 0) ? ~^byte_atual : ^byte_atual;
  // Line bits of the current byte, index = bit counter (0 = start, 10 = stop)
  assign quadro     = {1'b1, paridade, byte_atual, 1'b0};

  always_ff @(posedge clock) begin
    if (reset) begin
      estado   <= INICIAL;
      dado_q   <= '0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      gap_cnt  <= '0;
      byte_sel <= 1'b0;
      linha_q  <= 1'b1;
    end else begin
      estado   <= estado_n;
      dado_q   <= dado_n;
      baud_cnt <= baud_cnt_n;
      bit_cnt  <= bit_cnt_n;
      gap_cnt  <= gap_cnt_n;
      byte_sel <= byte_sel_n;
      linha_q  <= linha_n;
    end
  end

  always_comb begin
    estado_n   = estado;
    dado_n     = dado_q;
    baud_cnt_n = baud_cnt;
    bit_cnt_n  = bit_cnt;
    gap_cnt_n  = gap_cnt;
    byte_sel_n = byte_sel;
    linha_n    = linha_q;
    case (estado)
      INICIAL, FINAL: begin
        linha_n = 1'b1;
        if (partida) begin
          dado_n   = dados;
          estado_n = PREPARA;
        end else begin
          estado_n = INICIAL;
        end
      end
      PREPARA: begin
        estado_n   = TRANSMITE;
        byte_sel_n = 1'b0;
        bit_cnt_n  = '0;
        baud_cnt_n = '0;
        linha_n    = 1'b0;
      end
      TRANSMITE: begin
        if (baud_cnt == BAUD_LAST) begin
          baud_cnt_n = '0;
          if (bit_cnt == 4'd10) begin
            bit_cnt_n = '0;
            if (!byte_sel) begin
              if (GAP_CLKS == 0) begin
                byte_sel_n = 1'b1;
                linha_n    = 1'b0;
              end else begin
                estado_n  = INTERVALO;
                gap_cnt_n = '0;
                linha_n   = 1'b1;
              end
            end else begin
              estado_n = FINAL;
              linha_n  = 1'b1;
            end
          end else begin
            bit_cnt_n = bit_cnt + 4'd1;
            linha_n   = quadro[bit_cnt_n];
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      INTERVALO: begin
        if (gap_cnt == GAP_LAST) begin
          estado_n   = TRANSMITE;
          byte_sel_n = 1'b1;
          bit_cnt_n  = '0;
          baud_cnt_n = '0;
          linha_n    = 1'b0;
        end else begin
          gap_cnt_n = gap_cnt + 1'b1;
        end
      end
      default: begin
        estado_n = INICIAL;
        linha_n  = 1'b1;
      end
    endcase
  end

  assign saida_serial = linha_q;
  assign ocupado      = (estado == TRANSMITE) || (estado == INTERVALO);
  assign pronto       = (estado == FINAL);
  assign db_estado    = estado;

  assert property (@(posedge clock) M >= 2)
    else $error("tx_serial_16b: CLK_FREQ/BAUD must be at least 2");

endmodule

// File: tb/tb_tx_serial_16b.sv
// Directed bench: two instances (M=5 odd parity 1-bit gap; M=4 even parity no gap), per-cycle line/status model.
module tb_tx_serial_16b;

  logic        clock = 1'b0;
  logic        reset;
  logic        partida1, partida2;
  logic [15:0] dados;
  logic        line1, ocu1, pr1, line2, ocu2, pr2;
  logic [3:0]  st1, st2;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  tx_serial_16b #(.CLK_FREQ(50), .BAUD(10), .PARIDADE_IMPAR(1), .GAP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .partida(partida1), .dados(dados),
    .saida_serial(line1), .ocupado(ocu1), .pronto(pr1), .db_estado(st1));

  tx_serial_16b #(.CLK_FREQ(40), .BAUD(10), .PARIDADE_IMPAR(0), .GAP_BITS(0)) dut2 (
    .clock(clock), .reset(reset), .partida(partida2), .dados(dados),
    .saida_serial(line2), .ocupado(ocu2), .pronto(pr2), .db_estado(st2));

  typedef struct {
    bit          sel;
    logic [15:0] d;
    logic [10:0] e0;
    logic [10:0] e1;
    string       nm;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  function automatic logic g_line(bit s); return s ? line2 : line1; endfunction
  function automatic logic g_ocu(bit s);  return s ? ocu2 : ocu1;   endfunction
  function automatic logic g_pr(bit s);   return s ? pr2 : pr1;     endfunction
  function automatic logic [3:0] g_st(bit s); return s ? st2 : st1; endfunction

  task automatic set_partida(input bit s, input logic v);
    if (s) partida2 = v;
    else   partida1 = v;
  endtask

  // One word from the sampling edge N to one cycle past pronto; t counts edges after N.
  task automatic run_word(input bit sel, input logic [15:0] d, input logic [10:0] e0,
                          input logic [10:0] e1, input bit started, input bit hold,
                          input int poke_t, input bit chain, input logic [15:0] chain_d,
                          input string nm);
    int m, g, tt, idx, pos;
    int bad_line, bad_ocu, bad_pr, bad_st;
    logic exp_line, exp_ocu, exp_pr;
    logic [3:0] exp_st;
    logic [10:0] got0, got1;
    m = sel ? 4 : 5;
    g = sel ? 0 : 1;
    tt = (22 + g) * m;
    bad_line = 0; bad_ocu = 0; bad_pr = 0; bad_st = 0;
    got0 = '0; got1 = '0;
    if (!started) begin
      set_partida(sel, 1'b1);
      dados = d;
      @(posedge clock); #1;
    end
    if (!hold) set_partida(sel, 1'b0);
    if (g_line(sel) !== 1'b1) bad_line++;
    if (g_ocu(sel) !== 1'b0) bad_ocu++;
    if (g_pr(sel) !== 1'b0) bad_pr++;
    if (g_st(sel) !== 4'd1) bad_st++;
    for (int t = 1; t <= tt + 1; t++) begin
      @(posedge clock); #1;
      if (t <= tt) begin
        idx = t - 1;
        pos = idx / m;
        if (pos < 11) exp_line = e0[pos];
        else if (pos < 11 + g) exp_line = 1'b1;
        else exp_line = e1[pos - 11 - g];
        exp_ocu = 1'b1;
        exp_pr  = 1'b0;
        exp_st  = (pos >= 11 && pos < 11 + g) ? 4'd3 : 4'd2;
        if (idx % m == m / 2) begin
          if (pos < 11) got0[pos] = g_line(sel);
          else if (pos >= 11 + g) got1[pos - 11 - g] = g_line(sel);
        end
      end else begin
        exp_line = 1'b1; exp_ocu = 1'b0; exp_pr = 1'b1; exp_st = 4'd4;
      end
      if (g_line(sel) !== exp_line) bad_line++;
      if (g_ocu(sel) !== exp_ocu) bad_ocu++;
      if (g_pr(sel) !== exp_pr) bad_pr++;
      if (g_st(sel) !== exp_st) bad_st++;
      if (t == poke_t) begin
        set_partida(sel, 1'b1);
        dados = 16'hFFFF;
      end
      if (t == poke_t + 1 && !hold) set_partida(sel, 1'b0);
    end
    if (chain) begin
      set_partida(sel, 1'b1);
      dados = chain_d;
    end
    @(posedge clock); #1;
    if (g_line(sel) !== 1'b1) bad_line++;
    if (g_pr(sel) !== 1'b0) bad_pr++;
    if (g_st(sel) !== ((chain || hold) ? 4'd1 : 4'd0)) bad_st++;
    chk({nm, " byte0"}, 32'(got0), 32'(e0));
    chk({nm, " byte1"}, 32'(got1), 32'(e1));
    chk({nm, " line cycles wrong"}, bad_line, 0);
    chk({nm, " ocupado cycles wrong"}, bad_ocu, 0);
    chk({nm, " pronto cycles wrong"}, bad_pr, 0);
    chk({nm, " db_estado cycles wrong"}, bad_st, 0);
  endtask

  initial begin
    int pr_seen, low_seen;
    // Frame = {stop, parity, byte, start}; odd parity for dut1, even for dut2
    tbl[0] = '{1'b0, 16'h2202, 11'h404, 11'h644, "w2202"};
    tbl[1] = '{1'b0, 16'h1111, 11'h622, 11'h622, "w1111"};
    tbl[2] = '{1'b0, 16'h80A5, 11'h74A, 11'h500, "w80A5"};
    tbl[3] = '{1'b0, 16'h4003, 11'h606, 11'h480, "w4003"};
    tbl[4] = '{1'b1, 16'h00FF, 11'h5FE, 11'h400, "even00FF"};
    tbl[5] = '{1'b1, 16'h8001, 11'h602, 11'h700, "even8001"};

    reset = 1'b1; partida1 = 1'b0; partida2 = 1'b0; dados = 16'h0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset line", 32'(line1), 1);
    chk("reset ocupado", 32'(ocu1), 0);
    chk("reset pronto", 32'(pr1), 0);
    chk("reset db_estado", 32'(st1), 0);
    chk("reset dut2 outputs", 32'({line2, ocu2, pr2, st2}), 32'h40);
    partida1 = 1'b1;
    @(posedge clock); #1;
    chk("reset beats partida", 32'(st1), 0);
    partida1 = 1'b0;
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 6; i++) begin
      run_word(tbl[i].sel, tbl[i].d, tbl[i].e0, tbl[i].e1, 1'b0, 1'b0, -10, 1'b0, 16'h0, tbl[i].nm);
      repeat (3) @(posedge clock);
      #1;
    end

    // partida while busy with changed dados: ignored, original word sent
    run_word(1'b0, 16'h2202, 11'h404, 11'h644, 1'b0, 1'b0, 12, 1'b0, 16'h0, "ignore");
    repeat (2) @(posedge clock);
    #1;

    // partida in the pronto cycle starts the next word
    run_word(1'b0, 16'h1111, 11'h622, 11'h622, 1'b0, 1'b0, -10, 1'b1, 16'h4003, "chainA");
    run_word(1'b0, 16'h4003, 11'h606, 11'h480, 1'b1, 1'b0, -10, 1'b0, 16'h0, "chainB");
    repeat (2) @(posedge clock);
    #1;

    // partida held high restarts after pronto
    run_word(1'b0, 16'h2202, 11'h404, 11'h644, 1'b0, 1'b1, -10, 1'b0, 16'h0, "holdA");
    run_word(1'b0, 16'h2202, 11'h404, 11'h644, 1'b1, 1'b0, -10, 1'b0, 16'h0, "holdB");
    repeat (2) @(posedge clock);
    #1;

    // reset during d3 of byte 0 (t = 21..25)
    partida1 = 1'b1; dados = 16'h2202;
    @(posedge clock); #1;
    partida1 = 1'b0;
    repeat (23) @(posedge clock);
    #1;
    chk("abort line low at d3", 32'(line1), 0);
    chk("abort ocupado before", 32'(ocu1), 1);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    chk("abort line", 32'(line1), 1);
    chk("abort ocupado", 32'(ocu1), 0);
    chk("abort db_estado", 32'(st1), 0);
    pr_seen = 0; low_seen = 0;
    for (int k = 0; k < 150; k++) begin
      if (pr1) pr_seen++;
      if (!line1) low_seen++;
      @(posedge clock); #1;
    end
    chk("abort no pronto", pr_seen, 0);
    chk("abort line idle", low_seen, 0);
    run_word(1'b0, 16'h2202, 11'h404, 11'h644, 1'b0, 1'b0, -10, 1'b0, 16'h0, "after_abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_serial_16b.md
TX_SERIAL_16B -- requirements
Module: tx_serial_16b

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000; system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600; serial bit rate (115200 for the config channel).
REQ-003 Parameter PARIDADE_IMPAR, default 1; 1 = odd parity, 0 = even parity.
REQ-004 Parameter GAP_BITS, default 1; idle bit times inserted between byte 0 and byte 1.
REQ-005 clock  input  1  single system clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 partida  input  1  start request, sampled each rising edge.
REQ-008 dados  input  16  word to send; byte 0 = dados[7:0], byte 1 = dados[15:8].
REQ-009 saida_serial  output  1  UART line, idle high.
REQ-010 ocupado  output  1  high while a transmission is in progress.
REQ-011 pronto  output  1  one-cycle pulse at end of transmission.
REQ-012 db_estado  output  4  current FSM state code, for debug display.

Function
REQ-013 Bit period M = CLK_FREQ/BAUD (integer division). Each line bit SHALL be held for exactly M clocks; M = 5208 at 9600 baud, 434 at 115200.
REQ-014 Frame format: start bit 0, data d0..d7 LSB first, parity bit, stop bit 1; 11 bit times per byte.
REQ-015 Parity bit = ~^byte when PARIDADE_IMPAR=1 (data+parity has odd ones), ^byte when 0.
REQ-016 FSM states: INICIAL(0), PREPARA(1), TRANSMITE(2), INTERVALO(3), FINAL(4); other codes unused and SHALL return to INICIAL.
REQ-017 INICIAL: line 1, ocupado 0; partida=1 latches dados into an internal 16-bit register -> PREPARA.
REQ-018 partida is sampled at edge N. From edge N+1 saida_serial=0 (start bit of byte 0) and ocupado=1.
REQ-019 TRANSMITE shifts the latched byte using a bit counter (0..10) and a baud counter (0..M-1). After byte 0's stop bit, the FSM goes to INTERVALO. After byte 1's stop bit, it goes to FINAL.
REQ-020 INTERVALO holds the line at 1 for GAP_BITS*M clocks, then starts byte 1's start bit. With GAP_BITS=0, byte 1's start bit immediately follows byte 0's stop bit.
REQ-021 FINAL lasts one clock: pronto=1, ocupado=0, line 1 -> INICIAL. pronto occurs at edge N+(22+GAP_BITS)*M+1.
REQ-022 partida while ocupado=1 SHALL be ignored. Changes on dados after latching SHALL NOT affect the frame in flight.
REQ-023 partida asserted during the FINAL cycle SHALL be accepted. The next start bit begins the following cycle, with no idle gap.
REQ-024 partida held high continuously SHALL start a new word after each pronto. This is not an error.
REQ-025 saida_serial SHALL be driven from a register (glitch-free).
REQ-026 M < 2 is unsupported; a simulation assertion SHALL flag it.

Reset
REQ-027 On reset=1 at a rising edge, at that edge: state=INICIAL, saida_serial=1, ocupado=0, pronto=0, all counters and data register cleared, db_estado=0.
REQ-028 Reset mid-frame SHALL abort immediately. The line returns high at the next edge, with no partial stop bit or pronto.
REQ-029 reset has priority over partida in the same cycle.

Verification
REQ-030 BAUD=9600, dados=16'h2202, partida pulse at edge N -> line shows 0,0,1,0,0,0,0,0,0,0(parity),1 then 1 idle bit, then 0,0,1,0,0,0,1,0,0,1(parity),1. Each bit is 5208 clocks; pronto=1 only at N+119785.
REQ-031 BAUD=115200, dados=16'h1111 -> both bytes are 0x11 with parity 1; bits are 434 clocks; pronto at N+9983. A looped-back tusca receiver decodes 16'h1111 with no parity error.
REQ-032 partida again 1000 clocks after start, with dados changed to 16'hFFFF -> ignored; the original word is sent unchanged; exactly one pronto.
REQ-033 reset during bit d3 of byte 0 -> line 1 next edge, ocupado 0, no pronto; a fresh partida then sends a complete correct frame.
REQ-034 partida in the pronto cycle with dados=16'h4003 -> start bit begins on the next edge; second word is correct.
REQ-035 PARIDADE_IMPAR=0, dados=16'h00FF -> parity bit 0 for 0xFF and 0 for 0x00.
